// File: rtl/detect_edges_filtered_if.sv
// Signal bundle for the filtered multi-channel edge detector.
// master: drives raw inputs, clears and enables; slave: the detector itself.
interface detect_edges_filtered_if #(
    parameter int N = 4
);
    logic [N-1:0] x;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] rise_flag;
    logic [N-1:0] fall_flag;
    logic [N-1:0] clr_rise;
    logic [N-1:0] clr_fall;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic         irq;

    modport master (
        output x, clr_rise, clr_fall, rise_en, fall_en,
        input  level, rise, fall, rise_flag, fall_flag, irq
    );

    modport slave (
        input  x, clr_rise, clr_fall, rise_en, fall_en,
        output level, rise, fall, rise_flag, fall_flag, irq
    );
endinterface

// File: rtl/detect_edges_filtered.sv
// Multi-channel edge detector: optional synchroniser, glitch filter,
// registered rise/fall pulses, sticky flags with clear, maskable irq.
// Ports: clk, aresetn (async active-low), bus (slave side of the
// detect_edges_filtered_if bundle: x, level, rise, fall, flags, clears,
// enables, irq).
module detect_edges_filtered #(
    parameter int             N             = 4,
    parameter int             SYNC_STAGES   = 2,
    parameter int             FILTER_CYCLES = 4,
    parameter logic [N-1:0]   RESET_VALUE   = '0
) (
    input  logic                        clk,
    input  logic                        aresetn,
    detect_edges_filtered_if.slave      bus
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

    logic [N-1:0]  s;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  level_q;
    logic [N-1:0]  level_d;
    logic [N-1:0]  rise_q;
    logic [N-1:0]  fall_q;
    logic [N-1:0]  rflag_q;
    logic [N-1:0]  fflag_q;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = bus.x;
    end else begin : g_sync
        logic [N-1:0] q [SYNC_STAGES];

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                for (int k = 0; k < SYNC_STAGES; k++)
                    q[k] <= RESET_VALUE;
            end else begin
                q[0] <= bus.x;
                for (int k = 1; k < SYNC_STAGES; k++)
                    q[k] <= q[k-1];
            end
        end

        assign s = q[SYNC_STAGES-1];
    end

    // A level change is accepted only after FILTER_CYCLES consecutive
    // differing samples; any matching sample restarts the count.
    // Pulses come from comparing level with its own delayed copy, so
    // they trail the level change by one edge and reset cannot fake one.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N; i++)
                cnt[i] <= '0;
            level_q <= RESET_VALUE;
            level_d <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            rflag_q <= '0;
            fflag_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s[i] == level_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CMAX) begin
                    level_q[i] <= s[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            level_d <= level_q;
            rise_q  <= level_q & ~level_d;
            fall_q  <= ~level_q & level_d;
            // set has priority over a simultaneous clear
            rflag_q <= rise_q | (rflag_q & ~bus.clr_rise);
            fflag_q <= fall_q | (fflag_q & ~bus.clr_fall);
        end
    end

    assign bus.level     = level_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.rise_flag = rflag_q;
    assign bus.fall_flag = fflag_q;
    assign bus.irq       = |((rflag_q & bus.rise_en) |
                             (fflag_q & bus.fall_en));
endmodule

// File: tb/tb_detect_edges_filtered.sv
// Directed bench for detect_edges_filtered: default instance plus a
// SYNC_STAGES=0 / FILTER_CYCLES=1 instance.
module tb_detect_edges_filtered;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    detect_edges_filtered_if #(.N(4)) ia ();
    detect_edges_filtered_if #(.N(4)) ib ();

    detect_edges_filtered #(
        .N(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VALUE(4'b0000)
    ) dut_a (
        .clk(clk), .aresetn(aresetn), .bus(ia.slave)
    );

    detect_edges_filtered #(
        .N(4), .SYNC_STAGES(0), .FILTER_CYCLES(1), .RESET_VALUE(4'b0000)
    ) dut_b (
        .clk(clk), .aresetn(aresetn), .bus(ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel: 0 a.rise, 1 a.fall, 2 b.rise, 3 b.fall; n = edges waited, 99 on timeout
    task automatic wait_for(input int sel, input logic [3:0] mask,
                            output int n);
        logic [3:0] v;
        n = 99;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            case (sel)
                0: v = ia.rise;
                1: v = ia.fall;
                2: v = ib.rise;
                default: v = ib.fall;
            endcase
            if ((v & mask) != 4'b0) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int nr;
        int nf;
        logic seen;

        ia.x = '0; ia.clr_rise = '0; ia.clr_fall = '0;
        ia.rise_en = '0; ia.fall_en = '0;
        ib.x = '0; ib.clr_rise = '0; ib.clr_fall = '0;
        ib.rise_en = '0; ib.fall_en = '0;

        step(2);
        chk("rst_level", 32'(ia.level), 32'h0);
        chk("rst_pulse", 32'({ia.rise, ia.fall}), 32'h0);
        chk("rst_flags", 32'({ia.rise_flag, ia.fall_flag}), 32'h0);
        chk("rst_irq", 32'(ia.irq), 32'h0);

        aresetn = 1'b1;
        ia.x = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk($sformatf("lat_level_%0d", k), 32'(ia.level[0]),
                (k >= 6) ? 32'h1 : 32'h0);
            chk($sformatf("lat_rise_%0d", k), 32'(ia.rise),
                (k == 7) ? 32'h1 : 32'h0);
        end
        step(1);
        chk("rise_one_cycle", 32'(ia.rise), 32'h0);
        chk("rise_flag0", 32'(ia.rise_flag), 32'h1);
        chk("irq_masked", 32'(ia.irq), 32'h0);
        ia.rise_en = 4'b0001;
        #1;
        chk("irq_enabled", 32'(ia.irq), 32'h1);
        ia.rise_en = '0;
        ia.clr_rise = 4'b1111;
        step(1);
        ia.clr_rise = '0;
        chk("flag_cleared", 32'(ia.rise_flag), 32'h0);

        // 3-cycle glitch on channel 1 must be rejected
        ia.x[1] = 1'b1;
        step(3);
        ia.x[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            seen = seen | ia.rise[1] | ia.fall[1] | ia.level[1];
        end
        chk("glitch_reject", 32'(seen), 32'h0);

        // 4-cycle pulse is accepted: one rise, one fall
        nr = 0;
        nf = 0;
        ia.x[1] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (k == 4) ia.x[1] = 1'b0;
            nr += int'(ia.rise[1]);
            nf += int'(ia.fall[1]);
        end
        chk("pulse4_rise", 32'(nr), 32'd1);
        chk("pulse4_fall", 32'(nf), 32'd1);
        chk("pulse4_level", 32'(ia.level[1]), 32'h0);

        // clear racing with set on channel 2
        ia.rise_en = 4'b0100;
        ia.x[2] = 1'b1;
        wait_for(0, 4'b0100, n);
        chk("ch2_lat", 32'(n), 32'd7);
        ia.clr_rise[2] = 1'b1;
        step(1);
        chk("race_flag", 32'(ia.rise_flag[2]), 32'h1);
        chk("race_irq", 32'(ia.irq), 32'h1);
        step(1);
        chk("clr_flag", 32'(ia.rise_flag[2]), 32'h0);
        chk("clr_irq", 32'(ia.irq), 32'h0);
        ia.clr_rise = '0;
        ia.rise_en = '0;

        // all channels together
        ia.x = 4'b0000;
        step(20);
        ia.clr_rise = 4'b1111;
        ia.clr_fall = 4'b1111;
        step(1);
        ia.clr_rise = '0;
        ia.clr_fall = '0;
        ia.x = 4'b1111;
        wait_for(0, 4'b1111, n);
        chk("all_rise_lat", 32'(n), 32'd7);
        chk("all_rise", 32'(ia.rise), 32'hf);
        step(1);
        chk("all_rise_end", 32'(ia.rise), 32'h0);
        chk("all_rise_flag", 32'(ia.rise_flag), 32'hf);
        ia.x = 4'b0000;
        wait_for(1, 4'b1111, n);
        chk("all_fall_lat", 32'(n), 32'd7);
        chk("all_fall", 32'(ia.fall), 32'hf);
        step(1);
        chk("all_fall_end", 32'(ia.fall), 32'h0);
        chk("all_fall_flag", 32'(ia.fall_flag), 32'hf);

        // reset in the middle of filtering
        step(10);
        ia.clr_rise = 4'b1111;
        ia.clr_fall = 4'b1111;
        step(1);
        ia.clr_rise = '0;
        ia.clr_fall = '0;
        ia.x = 4'b1000;
        step(2);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_level", 32'(ia.level), 32'h0);
        chk("mid_rst_pulse", 32'({ia.rise, ia.fall}), 32'h0);
        chk("mid_rst_flags", 32'({ia.rise_flag, ia.fall_flag}), 32'h0);
        step(1);
        aresetn = 1'b1;
        chk("post_rst_level", 32'(ia.level), 32'h0);
        wait_for(0, 4'b1000, n);
        chk("post_rst_lat", 32'(n), 32'd7);

        // unsynchronised, unfiltered instance
        ib.x = 4'b0001;
        wait_for(2, 4'b0001, n);
        chk("b_rise_lat", 32'(n), 32'd2);
        ib.x = 4'b0000;
        wait_for(3, 4'b0001, n);
        chk("b_fall_lat", 32'(n), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
